uart_tx_rx_scheduler: RTL and testbench
=======================================

// Module: uart_tx_rx_scheduler
// PURPOSE
//  Sequences the UART datapath: round-robin arbitration of two byte requesters for the transmitter,
//  frame pacing of send/data on baud-tick edges, and the receiver's interrupt/acknowledge handshake
//  into a 1-entry hold register. Also applies baud configuration, but only while the link is idle.
//  Sits between host clients and the baud generator / transmitter / receiver.
// PARAMETERS
//  FRAME_TICKS  10  tick rising edges tx_send is held high per byte (start + 8 data + stop)
//  GAP_TICKS    1   tick rising edges with tx_send low between frames (>=1)
//  CNT_W        4   width of tick counter; must hold max(FRAME_TICKS,GAP_TICKS)
// PORTS
//  clk          in   1  system clock
//  reset        in   1  synchronous, active-high reset
//  baud_sel     in   2  requested baud rate code
//  baud         out  2  baud code driven to baud generator
//  tick         in   1  baud tick level from generator; sampled on clk
//  req0_valid   in   1  requester 0 has a byte
//  req0_data    in   8  requester 0 byte
//  req0_ready   out  1  1-cycle pulse: requester 0 byte accepted
//  req1_valid / req1_data / req1_ready    same for requester 1
//  tx_send      out  1  transmitter enable
//  tx_data      out  8  transmitter data byte, stable while tx_send=1
//  tx_busy      out  1  high in any state except IDLE
//  last_grant   out  1  index of most recently granted requester
//  rx_irq       in   1  receiver host_interrupt
//  rx_in_data   in   8  receiver output byte
//  rx_in_err    in   3  receiver error flags
//  rx_ack       out  1  to receiver host_aknowledged
//  rx_valid     out  1  hold register full
//  rx_data      out  8  held byte
//  rx_err       out  3  held error flags
//  rx_ready     in   1  host consumes held byte when rx_valid & rx_ready
// BEHAVIOUR
//  Reset (sync): state=IDLE; all outputs 0 incl. baud=2'b00, last_grant=0, tx_data=0, rx_*=0; tick_q=0.
//  tick_rise = tick & ~tick_q (tick_q registered each clk). All pacing counts tick_rise only.
//  TX FSM IDLE -> SEND -> GAP -> IDLE:
//   IDLE: baud <= baud_sel every cycle. If any reqN_valid: grant winner; if both valid, winner = ~last_grant.
//         Same clk edge: reqN_ready=1 for one cycle, tx_data<=reqN_data, last_grant<=N, tx_send<=1, cnt<=0, ->SEND.
//   SEND: cnt++ on tick_rise; on tick_rise with cnt==FRAME_TICKS-1: tx_send<=0, cnt<=0, ->GAP.
//   GAP:  cnt++ on tick_rise; on tick_rise with cnt==GAP_TICKS-1: ->IDLE.
//   Accept latency: valid seen in IDLE -> ready pulse and tx_send high on the next clk edge.
//   baud is frozen outside IDLE; baud_sel changes mid-frame take effect on return to IDLE.
//   reqN_ready never asserted outside IDLE; at most one ready per cycle; a requester dropping valid is not granted.
//   tx_data unchanged between accepts.
//  RX handshake:
//   Capture when rx_irq=1 & rx_ack=0 & (rx_valid=0 | rx_ready=1):
//    rx_data<=rx_in_data, rx_err<=rx_in_err, rx_valid<=1, rx_ack<=1.
//   rx_ack stays 1 until rx_irq sampled 0, then <=0 next edge; no new capture while rx_ack=1.
//   Hold full and no consume: no ack (backpressure); receiver keeps irq pending.
//   Consume without capture: rx_valid<=0. Consume and capture same cycle: new byte replaces old, rx_valid stays 1.
//  Reset mid-frame: tx_send drops on the reset edge; any in-flight byte is abandoned without retry.
//  TX and RX paths are independent and may act in the same cycle.
// TESTING
//  1 Reset: after reset, all outputs 0; baud follows baud_sel=2'b10 in IDLE one clk later.
//  2 Single: req0 0xA5 -> req0_ready pulse, tx_data=A5, tx_send high exactly 10 tick_rise, then low 1 tick_rise, then IDLE.
//  3 Contention: both valid (0x11, 0x22), last_grant=0 -> req1 first, then req0; alternation holds over 4 bytes.
//  4 Baud freeze: baud_sel 01->11 mid-SEND -> baud stays 01 until IDLE, then 11.
//  5 RX: rx_irq with 0x3C, err=3'b010 -> rx_valid=1, data/err held, rx_ack held until irq low;
//    second irq while full and rx_ready=0 -> no ack until consumed.
//  6 Reset mid-SEND: reset pulse at 5th tick -> tx_send=0, state IDLE, next request transmits full 10 ticks.

Source files
------------

// File: rtl/uart_tx_rx_scheduler.sv
// uart_tx_rx_scheduler
//   Sequences the UART datapath between host clients and the baud generator,
//   transmitter and receiver:
//     - round-robin arbitration of two byte requesters onto the transmitter,
//     - frame pacing of tx_send/tx_data counted in baud-tick rising edges,
//     - receiver interrupt/acknowledge handshake into a 1-entry hold register,
//     - baud code forwarding, applied only while the transmit path is idle.
//
// Ports
//   clk, reset                 system clock, synchronous active-high reset
//   baud_sel -> baud           requested / applied baud code
//   tick                       baud tick level from the generator
//   reqN_valid/data/ready      requester N byte handshake (ready is a 1-cycle pulse)
//   tx_send, tx_data           transmitter enable and byte
//   tx_busy, last_grant        status: not idle / most recent grant index
//   rx_irq, rx_in_data/err     receiver interrupt and byte/error flags
//   rx_ack                     acknowledge back to the receiver
//   rx_valid, rx_data, rx_err  hold register contents
//   rx_ready                   host consumes the held byte
module uart_tx_rx_scheduler #(
    parameter int FRAME_TICKS = 10,
    parameter int GAP_TICKS   = 1,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] baud_sel,
    output logic [1:0] baud,
    input  logic       tick,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx_send,
    output logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       last_grant,
    input  logic       rx_irq,
    input  logic [7:0] rx_in_data,
    input  logic [2:0] rx_in_err,
    output logic       rx_ack,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic [2:0] rx_err,
    input  logic       rx_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_TICKS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             tick_q;
    logic             tick_rise;
    logic             grant;
    logic             grant_idx;
    logic             frame_done;
    logic             gap_done;
    logic             rx_capture;
    logic             rx_consume;

    // Only the rising edge of the tick level advances frame pacing.
    assign tick_rise  = tick & ~tick_q;

    // When both requesters want the link, the one not served last wins.
    assign grant      = (state == ST_IDLE) & (req0_valid | req1_valid);
    assign grant_idx  = (req0_valid & req1_valid) ? ~last_grant : req1_valid;

    assign frame_done = (state == ST_SEND) & tick_rise & (cnt == FRAME_LAST);
    assign gap_done   = (state == ST_GAP)  & tick_rise & (cnt == GAP_LAST);

    // A capture needs a free (or simultaneously emptied) hold register and
    // no acknowledge still outstanding for the previous interrupt.
    assign rx_capture = rx_irq & ~rx_ack & (~rx_valid | rx_ready);
    assign rx_consume = rx_valid & rx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant)      state_nxt = ST_SEND;
            ST_SEND: if (frame_done) state_nxt = ST_GAP;
            ST_GAP:  if (gap_done)   state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_send = (state == ST_SEND);
        tx_busy = (state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q     <= 1'b0;
            cnt        <= '0;
            baud       <= 2'b00;
            tx_data    <= 8'h00;
            last_grant <= 1'b0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
        end else begin
            tick_q     <= tick;
            req0_ready <= grant & ~grant_idx;
            req1_ready <= grant &  grant_idx;
            // Baud changes are deferred until the link is idle so a frame
            // never straddles two rates.
            if (state == ST_IDLE) begin
                baud <= baud_sel;
            end
            if (grant) begin
                tx_data    <= grant_idx ? req1_data : req0_data;
                last_grant <= grant_idx;
                cnt        <= '0;
            end else if (frame_done) begin
                cnt <= '0;
            end else if (tick_rise && (state != ST_IDLE)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_ack   <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
            rx_err   <= 3'b000;
        end else begin
            if (rx_ack && !rx_irq) begin
                rx_ack <= 1'b0;
            end else if (rx_capture) begin
                rx_ack <= 1'b1;
            end
            if (rx_capture) begin
                rx_data  <= rx_in_data;
                rx_err   <= rx_in_err;
                rx_valid <= 1'b1;
            end else if (rx_consume) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_rx_scheduler.sv
module tb_uart_tx_rx_scheduler;

    localparam int FRAME = 10;
    localparam int GAP   = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] baud_sel;
    logic [1:0] baud;
    logic       tick;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       tx_send;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       last_grant;
    logic       rx_irq;
    logic [7:0] rx_in_data;
    logic [2:0] rx_in_err;
    logic       rx_ack;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [2:0] rx_err;
    logic       rx_ready;

    uart_tx_rx_scheduler #(
        .FRAME_TICKS(FRAME),
        .GAP_TICKS  (GAP),
        .CNT_W      (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .baud_sel  (baud_sel),
        .baud      (baud),
        .tick      (tick),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .tx_send   (tx_send),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .last_grant(last_grant),
        .rx_irq    (rx_irq),
        .rx_in_data(rx_in_data),
        .rx_in_err (rx_in_err),
        .rx_ack    (rx_ack),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_err    (rx_err),
        .rx_ready  (rx_ready)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Baud tick level: high for one clock out of every four.
    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    // Behavioural model: a link is either free or carrying a frame with a
    // number of frame ticks and gap ticks still to go.
    logic       m_tickq, m_busy, m_last, m_rdy0, m_rdy1, m_ack, m_rxv;
    int         m_frame_left, m_gap_left;
    logic [1:0] m_baud;
    logic [7:0] m_txd, m_rxd;
    logic [2:0] m_rxe;
    logic       m_rise, m_win, m_cap, m_send;

    assign m_rise = tick & ~m_tickq;
    assign m_win  = (req0_valid & req1_valid) ? ~m_last : req1_valid;
    assign m_cap  = rx_irq & ~m_ack & (~m_rxv | rx_ready);
    assign m_send = m_busy && (m_frame_left != 0);

    always @(posedge clk) begin
        if (reset) begin
            m_tickq <= 1'b0; m_busy <= 1'b0; m_last <= 1'b0;
            m_rdy0 <= 1'b0; m_rdy1 <= 1'b0; m_ack <= 1'b0; m_rxv <= 1'b0;
            m_frame_left <= 0; m_gap_left <= 0;
            m_baud <= 2'b00; m_txd <= 8'h00; m_rxd <= 8'h00; m_rxe <= 3'b000;
        end else begin
            m_tickq <= tick;
            m_rdy0  <= 1'b0;
            m_rdy1  <= 1'b0;
            if (!m_busy) begin
                m_baud <= baud_sel;
                if (req0_valid || req1_valid) begin
                    m_last       <= m_win;
                    m_txd        <= m_win ? req1_data : req0_data;
                    m_rdy0       <= ~m_win;
                    m_rdy1       <= m_win;
                    m_busy       <= 1'b1;
                    m_frame_left <= FRAME;
                    m_gap_left   <= GAP;
                end
            end else if (m_rise) begin
                if (m_frame_left != 0) begin
                    m_frame_left <= m_frame_left - 1;
                end else if (m_gap_left <= 1) begin
                    m_gap_left <= 0;
                    m_busy     <= 1'b0;
                end else begin
                    m_gap_left <= m_gap_left - 1;
                end
            end
            if (m_ack && !rx_irq) m_ack <= 1'b0;
            else if (m_cap)       m_ack <= 1'b1;
            if (m_cap) begin
                m_rxv <= 1'b1;
                m_rxd <= rx_in_data;
                m_rxe <= rx_in_err;
            end else if (m_rxv && rx_ready) begin
                m_rxv <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_tx_send",    32'(tx_send),    32'(m_send));
            chk("cyc_tx_busy",    32'(tx_busy),    32'(m_busy));
            chk("cyc_tx_data",    32'(tx_data),    32'(m_txd));
            chk("cyc_last_grant", 32'(last_grant), 32'(m_last));
            chk("cyc_req0_ready", 32'(req0_ready), 32'(m_rdy0));
            chk("cyc_req1_ready", 32'(req1_ready), 32'(m_rdy1));
            chk("cyc_baud",       32'(baud),       32'(m_baud));
            chk("cyc_rx_ack",     32'(rx_ack),     32'(m_ack));
            chk("cyc_rx_valid",   32'(rx_valid),   32'(m_rxv));
            chk("cyc_rx_data",    32'(rx_data),    32'(m_rxd));
            chk("cyc_rx_err",     32'(rx_err),     32'(m_rxe));
        end
    end

    // Frame monitor: counts tick rises seen while tx_send was high and while
    // in the inter-frame gap, restarting at every accept pulse.
    logic snap_send, snap_busy, snap_rdy, mon_tickq;
    int   send_rises, gap_rises;

    always @(negedge clk) begin
        snap_send <= tx_send;
        snap_busy <= tx_busy;
        snap_rdy  <= req0_ready | req1_ready;
    end

    always @(posedge clk) begin
        mon_tickq <= tick;
        if (snap_rdy) begin
            send_rises <= (tick && !mon_tickq) ? 1 : 0;
            gap_rises  <= 0;
        end else if (tick && !mon_tickq) begin
            if (snap_send)      send_rises <= send_rises + 1;
            else if (snap_busy) gap_rises  <= gap_rises + 1;
        end
    end

    task automatic wait_ready(input int bound, output int which);
        which = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (req0_ready) begin which = 0; return; end
            if (req1_ready) begin which = 1; return; end
        end
        timeout_fail("wait_ready");
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!tx_busy) return;
        end
        timeout_fail("wait_idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int  w;
        int  exp_w;
        bit  found;

        send_rises = 0;
        gap_rises  = 0;
        reset      = 1'b1;
        baud_sel   = 2'b10;
        req0_valid = 1'b0; req0_data = 8'h00;
        req1_valid = 1'b0; req1_data = 8'h00;
        rx_irq     = 1'b0; rx_in_data = 8'h00; rx_in_err = 3'b000;
        rx_ready   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_tx_send",    32'(tx_send),    32'h0);
        chk("rst_tx_busy",    32'(tx_busy),    32'h0);
        chk("rst_baud",       32'(baud),       32'h0);
        chk("rst_last_grant", 32'(last_grant), 32'h0);
        chk("rst_tx_data",    32'(tx_data),    32'h0);
        chk("rst_rx_valid",   32'(rx_valid),   32'h0);
        chk("rst_rx_ack",     32'(rx_ack),     32'h0);
        chk("rst_ready",      32'(req0_ready | req1_ready), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("t1_baud_follow", 32'(baud), 32'h2);

        // Single byte from requester 0
        req0_data  = 8'hA5;
        req0_valid = 1'b1;
        wait_ready(10, w);
        req0_valid = 1'b0;
        chk("t2_grant",   32'(w),       32'h0);
        chk("t2_tx_data", 32'(tx_data), 32'hA5);
        chk("t2_tx_send", 32'(tx_send), 32'h1);
        wait_idle(200);
        chk("t2_send_rises", 32'(send_rises), 32'd10);
        chk("t2_gap_rises",  32'(gap_rises),  32'd1);

        // Contention: both requesters hold valid for four bytes
        req0_data  = 8'h11;
        req1_data  = 8'h22;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ready(200, w);
            exp_w = (k % 2 == 0) ? 1 : 0;
            chk("t3_grant",      32'(w),          32'(exp_w));
            chk("t3_last_grant", 32'(last_grant), 32'(exp_w));
            chk("t3_tx_data",    32'(tx_data),    (exp_w == 1) ? 32'h22 : 32'h11);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle(200);

        // Baud freeze during a frame
        baud_sel = 2'b01;
        @(negedge clk);
        chk("t4_baud_idle", 32'(baud), 32'h1);
        req0_data  = 8'h5A;
        req0_valid = 1'b1;
        wait_ready(10, w);
        req0_valid = 1'b0;
        repeat (8) @(negedge clk);
        baud_sel = 2'b11;
        repeat (8) @(negedge clk);
        chk("t4_baud_frozen", 32'(baud), 32'h1);
        wait_idle(200);
        chk("t4_baud_at_idle", 32'(baud), 32'h1);
        @(negedge clk);
        chk("t4_baud_new", 32'(baud), 32'h3);

        // RX handshake and backpressure
        rx_in_data = 8'h3C;
        rx_in_err  = 3'b010;
        rx_irq     = 1'b1;
        @(negedge clk);
        chk("t5_rx_valid", 32'(rx_valid), 32'h1);
        chk("t5_rx_ack",   32'(rx_ack),   32'h1);
        chk("t5_rx_data",  32'(rx_data),  32'h3C);
        chk("t5_rx_err",   32'(rx_err),   32'h2);
        repeat (2) @(negedge clk);
        chk("t5_ack_held", 32'(rx_ack), 32'h1);
        rx_irq = 1'b0;
        @(negedge clk);
        chk("t5_ack_drop",   32'(rx_ack),   32'h0);
        chk("t5_still_full", 32'(rx_valid), 32'h1);
        rx_in_data = 8'hC3;
        rx_in_err  = 3'b101;
        rx_irq     = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_backpressure_ack", 32'(rx_ack),  32'h0);
        chk("t5_backpressure_dat", 32'(rx_data), 32'h3C);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("t5_replace_data",  32'(rx_data),  32'hC3);
        chk("t5_replace_err",   32'(rx_err),   32'h5);
        chk("t5_replace_valid", 32'(rx_valid), 32'h1);
        chk("t5_replace_ack",   32'(rx_ack),   32'h1);
        rx_irq = 1'b0;
        repeat (2) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("t5_consumed", 32'(rx_valid), 32'h0);

        // Reset in the middle of a frame
        req0_data  = 8'h77;
        req0_valid = 1'b1;
        wait_ready(10, w);
        req0_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (send_rises == 5) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) timeout_fail("t6_wait_5th_tick");
        chk("t6_mid_send", 32'(tx_send), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_send_dropped", 32'(tx_send), 32'h0);
        chk("t6_busy_dropped", 32'(tx_busy), 32'h0);
        req1_data  = 8'h99;
        req1_valid = 1'b1;
        wait_ready(10, w);
        req1_valid = 1'b0;
        chk("t6_grant",   32'(w),       32'h1);
        chk("t6_tx_data", 32'(tx_data), 32'h99);
        wait_idle(200);
        chk("t6_send_rises", 32'(send_rises), 32'd10);
        chk("t6_gap_rises",  32'(gap_rises),  32'd1);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
